// File: rtl/adder_sched_pkg.sv
// Shared state encoding and default widths for the adder operation scheduler.
package adder_sched_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 3;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ_A = 3'd1,
    ST_READ_B = 3'd2,
    ST_LATCH  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/adder_sched_ns.sv
// Next-state, next write-address, next result-count and full-flag logic
// for the adder operation scheduler.
module adder_sched_ns
  import adder_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  state_t            state,
  input  logic              op_start,
  input  logic              op_clear,
  input  logic              fifo_empty,
  input  logic              add_done,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W:0]   res_count,
  input  logic              res_full,
  output state_t            state_nxt,
  output logic [ADDR_W-1:0] waddr_nxt,
  output logic [ADDR_W:0]   count_nxt,
  output logic              full_nxt
);

  always_comb begin
    state_nxt = state;
    waddr_nxt = waddr;
    count_nxt = res_count;
    full_nxt  = res_full;
    if (op_clear) begin
      state_nxt = ST_IDLE;
      waddr_nxt = '0;
      count_nxt = '0;
      full_nxt  = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (op_start) state_nxt = fifo_empty ? ST_DONE : ST_READ_A;
        end
        ST_READ_A: state_nxt = ST_READ_B;
        ST_READ_B: state_nxt = ST_LATCH;
        ST_LATCH:  state_nxt = ST_EXEC;
        ST_EXEC: begin
          if (add_done) state_nxt = ST_WRITE;
        end
        ST_WRITE: begin
          waddr_nxt = waddr + ADDR_W'(1);
          count_nxt = res_count + (ADDR_W + 1)'(1);
          // Last slot of the result memory: stop, and flag overflow if work remains.
          if (&waddr) begin
            state_nxt = ST_DONE;
            if (!fifo_empty) full_nxt = 1'b1;
          end else if (fifo_empty) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_READ_A;
          end
        end
        ST_DONE: begin
          if (!op_start) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/adder_op_sched.sv
// Scheduler that pops operand pairs from the FIFO, runs them through the shared
// adder core and writes each sum to the result memory at an incrementing address.
//
// state   | meaning
// IDLE    | waiting for op_start
// READ_A  | pop first operand
// READ_B  | capture A, pop B if the FIFO still has data (else odd)
// LATCH   | capture B (0 when odd)
// EXEC    | launch adder, wait for add_done
// WRITE   | write sum to result memory, advance address/count
// DONE    | run finished, hold until op_start drops
module adder_op_sched
  import adder_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_start,
  input  logic              op_clear,
  input  logic [CNT_W-1:0]  fifo_data_count,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  output logic              add_start,
  input  logic              add_done,
  input  logic [DATA_W-1:0] add_result,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_wdata,
  output logic              busy,
  output logic              op_done,
  output logic              res_full,
  output logic [ADDR_W:0]   res_count
);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   waddr;
  logic [ADDR_W-1:0]   waddr_nxt;
  logic [ADDR_W:0]     count_nxt;
  logic                full_nxt;
  logic                odd;
  logic                exec_first;
  logic [DATA_W-1:0]   sum;
  logic                fifo_empty;

  assign fifo_empty = (fifo_data_count == '0);

  adder_sched_ns #(.ADDR_W(ADDR_W)) u_ns (
    .state      (state),
    .op_start   (op_start),
    .op_clear   (op_clear),
    .fifo_empty (fifo_empty),
    .add_done   (add_done),
    .waddr      (waddr),
    .res_count  (res_count),
    .res_full   (res_full),
    .state_nxt  (state_nxt),
    .waddr_nxt  (waddr_nxt),
    .count_nxt  (count_nxt),
    .full_nxt   (full_nxt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      waddr      <= '0;
      res_count  <= '0;
      res_full   <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      sum        <= '0;
      odd        <= 1'b0;
      exec_first <= 1'b0;
    end else begin
      state     <= state_nxt;
      waddr     <= waddr_nxt;
      res_count <= count_nxt;
      res_full  <= full_nxt;
      if (op_clear) begin
        exec_first <= 1'b0;
      end else begin
        unique case (state)
          ST_READ_B: begin
            add_a <= fifo_dout;
            odd   <= fifo_empty;
          end
          ST_LATCH: begin
            add_b      <= odd ? '0 : fifo_dout;
            exec_first <= 1'b1;
          end
          ST_EXEC: begin
            exec_first <= 1'b0;
            // add_done outside EXEC never reaches here, so stray pulses are dropped.
            if (add_done) sum <= add_result;
          end
          default: ;
        endcase
      end
    end
  end

  // Strobes are suppressed in the clear cycle so an abort never leaks a pop or write.
  assign fifo_rd_en = !op_clear &&
                      ((state == ST_READ_A) || ((state == ST_READ_B) && !fifo_empty));
  assign add_start  = !op_clear && (state == ST_EXEC) && exec_first;
  assign res_we     = !op_clear && (state == ST_WRITE);
  assign res_addr   = waddr;
  assign res_wdata  = sum;
  assign busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign op_done    = (state == ST_DONE);

endmodule

// File: tb/tb_adder_op_sched.sv
// Bench for adder_op_sched: behavioural FIFO and adder models, a write monitor,
// and an expected-result queue built from the operands loaded into the FIFO.
module tb_adder_op_sched;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int CW = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          op_start;
  logic          op_clear;
  logic [CW-1:0] fifo_data_count;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd_en;
  logic [DW-1:0] add_a, add_b;
  logic          add_start;
  logic          add_done = 1'b0;
  logic [DW-1:0] add_result = '0;
  logic          res_we;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_wdata;
  logic          busy, op_done, res_full;
  logic [AW:0]   res_count;

  adder_op_sched #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .fifo_data_count(fifo_data_count), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .add_a(add_a), .add_b(add_b), .add_start(add_start), .add_done(add_done),
    .add_result(add_result), .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata),
    .busy(busy), .op_done(op_done), .res_full(res_full), .res_count(res_count)
  );

  always #5 clk = ~clk;

  // FIFO model: the initial block owns wr_ptr, the FIFO process owns rd_ptr.
  logic [DW-1:0] fmem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops   = 0;
  assign fifo_data_count = CW'(wr_ptr - rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_dout <= fmem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
      pops      <= pops + 1;
    end
  end

  // Adder model with programmable latency, independent of reset_n.
  int lat = 2;
  int cd  = 0;
  logic [DW-1:0] sa = '0, sb = '0;
  always @(posedge clk) begin
    add_done <= 1'b0;
    if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        add_done   <= 1'b1;
        add_result <= sa + sb;
      end
    end
    if (add_start) begin
      sa <= add_a;
      sb <= add_b;
      cd <= lat;
    end
  end

  // Result memory write monitor.
  logic [AW-1:0] wa [0:255];
  logic [DW-1:0] wd [0:255];
  int wn = 0;
  always @(negedge clk) begin
    if (res_we) begin
      wa[wn % 256] = res_addr;
      wd[wn % 256] = res_wdata;
      wn = wn + 1;
    end
  end

  int tests = 0;
  int fails = 0;
  int rd_idx = 0;
  logic [AW-1:0] exp_a [$];
  logic [DW-1:0] exp_d [$];
  logic [DW-1:0] words [$];
  int  m_waddr = 0;
  int  m_count = 0;

  task automatic flush_fifo();
    wr_ptr = rd_ptr;
  endtask

  task automatic load_fifo();
    flush_fifo();
    foreach (words[i]) begin
      fmem[wr_ptr % 64] = words[i];
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic drain_check(input string name);
    while (exp_a.size() > 0) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      ea = exp_a.pop_front();
      ed = exp_d.pop_front();
      tests++;
      if (rd_idx >= wn) begin
        fails++;
        $display("FAIL %s write: got none, expected addr %0d data %0d", name, ea, ed);
      end else begin
        if (wa[rd_idx % 256] !== ea || wd[rd_idx % 256] !== ed) begin
          fails++;
          $display("FAIL %s write: got addr %0d data %0d, expected addr %0d data %0d",
                   name, wa[rd_idx % 256], wd[rd_idx % 256], ea, ed);
        end
        rd_idx++;
      end
    end
    tests++;
    if (wn != rd_idx) begin
      fails++;
      $display("FAIL %s extra writes: got %0d, expected 0", name, wn - rd_idx);
    end
    rd_idx = wn;
  endtask

  task automatic wait_add_start(input string name);
    int cyc = 0;
    while (!add_start && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (!add_start) begin
      fails++;
      $display("FAIL %s add_start timeout: got 0, expected 1", name);
    end
  endtask

  // Run everything currently in 'words' and check writes, pops, count and flags.
  task automatic run_words(input string name);
    int n, pairs, room, writes, exp_pops, left, p0, cyc;
    logic exp_full;
    n = words.size();
    pairs = (n + 1) / 2;
    room = DEPTH - m_waddr;
    writes = (pairs < room) ? pairs : room;
    exp_pops = (2 * writes < n) ? 2 * writes : n;
    left = n - exp_pops;
    exp_full = (writes == room) && (n > 2 * writes);
    for (int k = 0; k < writes; k++) begin
      logic [DW-1:0] a, b;
      a = words[2 * k];
      b = (2 * k + 1 < n) ? words[2 * k + 1] : '0;
      exp_a.push_back(AW'(m_waddr + k));
      exp_d.push_back(a + b);
    end
    load_fifo();
    p0 = pops;
    op_start = 1'b1;
    cyc = 0;
    while (!op_done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (!op_done) begin
      fails++;
      $display("FAIL %s op_done timeout: got 0, expected 1", name);
    end
    drain_check(name);
    m_waddr = (m_waddr + writes) % DEPTH;
    m_count = m_count + writes;
    tests++;
    if (res_count !== (AW + 1)'(m_count)) begin
      fails++;
      $display("FAIL %s res_count: got %0d, expected %0d", name, res_count, m_count);
    end
    tests++;
    if (res_full !== exp_full) begin
      fails++;
      $display("FAIL %s res_full: got %0b, expected %0b", name, res_full, exp_full);
    end
    tests++;
    if (pops - p0 != exp_pops || fifo_data_count !== CW'(left)) begin
      fails++;
      $display("FAIL %s fifo: got pops %0d count %0d, expected pops %0d count %0d",
               name, pops - p0, fifo_data_count, exp_pops, left);
    end
    tests++;
    if (res_addr !== AW'(m_waddr) || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s waddr/busy: got %0d/%0b, expected %0d/0", name, res_addr, busy, m_waddr);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (op_done !== 1'b1) begin
      fails++;
      $display("FAIL %s op_done hold: got %0b, expected 1", name, op_done);
    end
    op_start = 1'b0;
    @(negedge clk);
    tests++;
    if (op_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s return idle: got op_done %0b busy %0b, expected 0 0", name, op_done, busy);
    end
    flush_fifo();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({fifo_rd_en, add_a, add_b, add_start, res_we, res_addr, res_wdata,
         busy, op_done, res_full, res_count} !== '0) begin
      fails++;
      $display("FAIL reset outputs: got nonzero, expected all 0");
    end
    reset_n = 1'b1;
    @(negedge clk);
    // Reset mid-EXEC with a slow adder; its late done must not write.
    lat = 8;
    words = '{32'd11, 32'd22};
    load_fifo();
    op_start = 1'b1;
    wait_add_start("reset_mid_exec");
    @(negedge clk);
    reset_n = 1'b0;
    op_start = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, op_done, add_start, res_we, fifo_rd_en, res_count, res_addr, add_a, add_b} !== '0) begin
      fails++;
      $display("FAIL reset_mid_exec: got busy %0b res_count %0d add_a %0d, expected 0", busy, res_count, add_a);
    end
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    tests++;
    if (wn != rd_idx || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_late_done: got writes %0d busy %0b, expected 0 0", wn - rd_idx, busy);
    end
    rd_idx = wn;
    lat = 2;
    flush_fifo();
    m_waddr = 0;
    m_count = 0;
  endtask

  task automatic test_even_pairs();
    words = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_words("even_pairs");
  endtask

  task automatic test_odd_tail();
    words = '{32'd5, 32'd6, 32'd9};
    run_words("odd_tail");
  endtask

  task automatic test_back_to_back_fill();
    words = '{32'hFFFF_FFFF, 32'd2, 32'd70, 32'd80};
    run_words("wrap_add");
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back(DW'(i * 3 + 1));
    run_words("fill_full");
  endtask

  task automatic test_clear();
    lat = 6;
    words = '{32'd10, 32'd20, 32'd30, 32'd40};
    load_fifo();
    op_start = 1'b1;
    wait_add_start("clear");
    @(negedge clk);
    op_clear = 1'b1;
    op_start = 1'b0;
    #1;
    tests++;
    if ({fifo_rd_en, add_start, res_we} !== 3'b000) begin
      fails++;
      $display("FAIL clear strobes: got %03b, expected 000", {fifo_rd_en, add_start, res_we});
    end
    @(negedge clk);
    op_clear = 1'b0;
    tests++;
    if (busy !== 1'b0 || res_addr !== '0 || res_count !== '0 || res_full !== 1'b0) begin
      fails++;
      $display("FAIL clear state: got busy %0b addr %0d count %0d full %0b, expected 0 0 0 0",
               busy, res_addr, res_count, res_full);
    end
    repeat (10) @(negedge clk);
    tests++;
    if (wn != rd_idx || busy !== 1'b0) begin
      fails++;
      $display("FAIL clear late_done: got writes %0d busy %0b, expected 0 0", wn - rd_idx, busy);
    end
    rd_idx = wn;
    m_waddr = 0;
    m_count = 0;
    lat = 2;
    flush_fifo();
    words = '{32'd100, 32'd200};
    run_words("after_clear");
  endtask

  task automatic test_empty_start();
    int p0;
    flush_fifo();
    p0 = pops;
    op_start = 1'b1;
    @(negedge clk);
    tests++;
    if (op_done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL empty_start: got op_done %0b busy %0b, expected 1 0", op_done, busy);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (op_done !== 1'b1 || pops != p0 || res_count !== (AW + 1)'(m_count)) begin
      fails++;
      $display("FAIL empty_hold: got op_done %0b pops %0d count %0d, expected 1 0 %0d",
               op_done, pops - p0, res_count, m_count);
    end
    op_start = 1'b0;
    @(negedge clk);
    tests++;
    if (op_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL empty_idle: got op_done %0b busy %0b, expected 0 0", op_done, busy);
    end
    drain_check("empty_start");
  endtask

  initial begin
    reset_n  = 1'b0;
    op_start = 1'b0;
    op_clear = 1'b0;
    test_reset();
    test_even_pairs();
    test_odd_tail();
    test_back_to_back_fill();
    test_clear();
    test_empty_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
